traffic_phase_ctrl: RTL
=======================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 CLK_PER_TICK, 50000000, clk cycles per timing tick (1 s at 50 MHz); SHALL be >=1.
REQ-002 HWY_MIN_GREEN, 10, minimum highway green in ticks; SHALL be >=1.
REQ-003 FARM_MAX_GREEN, 9, maximum farm green in ticks; SHALL be >=FARM_MIN_GREEN.
REQ-004 FARM_MIN_GREEN, 2, minimum farm green before gap-out, in ticks; SHALL be >=1.
REQ-005 YELLOW, 3, yellow duration for either road, in ticks; SHALL be >=1.
REQ-006 ALL_RED, 1, all-red clearance duration, in ticks; SHALL be >=1.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 v  in  1  farm-road vehicle sensor, active high, synchronous to clk.
REQ-010 highway  out  3  highway lamps {red,yellow,green}: 100 red, 010 yellow, 001 green.
REQ-011 farm  out  3  farm lamps, same encoding.
REQ-012 phase  out  3  current state code, for debug.

Function
REQ-013 States SHALL be HG, HY, AR_F, FG, FY, AR_H. Lamps: HG 001/100, HY 010/100, AR_F 100/100, FG 100/001, FY 100/010, AR_H 100/100 (highway/farm).
REQ-014 Lamps and phase SHALL be registered Moore outputs decoded from the state register; no combinational path from v.
REQ-015 A tick pulse SHALL be high for one clk every CLK_PER_TICK cycles; prescaler counter wraps to 0 on the tick.
REQ-016 State, timer and sensor sampling SHALL change only on clk edges with tick high; v is ignored between ticks.
REQ-017 Timer SHALL count completed ticks in the current state, clear to 0 on every transition, width $clog2 of the largest duration plus 1.
REQ-018 HG to HY when timer >= HWY_MIN_GREEN-1 and v=1 at a tick; otherwise stay, timer saturating at HWY_MIN_GREEN-1.
REQ-019 HY to AR_F, AR_F to FG, FY to AR_H, AR_H to HG each after exactly YELLOW / ALL_RED ticks (transition on tick where timer = DUR-1).
REQ-020 FG to FY at tick where timer = FARM_MAX_GREEN-1, or earlier (gap-out) at a tick where v=0 and timer >= FARM_MIN_GREEN-1.
REQ-021 No state SHALL ever drive green or yellow on both roads; unreachable state codes SHALL recover to HG on the next clk.

Reset
REQ-022 rst low SHALL immediately force state HG, timer 0, prescaler 0, highway=001, farm=100, phase=HG code, independent of clk.
REQ-023 Reset asserted mid-phase SHALL abandon the phase; after release HG restarts its minimum green from 0.

Configuration
REQ-024 With PED_REQ_EN defined: ports ped_req (in, 1) and ped_walk (out, 1) exist; a ped_req pulse of any length SHALL set a pending latch that acts as v=1 for the HG exit decision, clears on entering FG, and ped_walk=1 exactly while in FG; reset clears the latch and ped_walk.
REQ-025 Without PED_REQ_EN: neither port exists, no latch exists, behaviour is REQ-013..REQ-023 only.

Structure
REQ-026 Shared package traffic_pkg SHALL hold the state enum typedef and the lamp constants RED, YELLOW, GREEN.
REQ-027 Prescaler SHALL be a separate sub-module tick_gen (clk, rst, tick) parametrised by CLK_PER_TICK.

Verification (bench params: CLK_PER_TICK=4, HWY_MIN_GREEN=3, FARM_MAX_GREEN=4, FARM_MIN_GREEN=2, YELLOW=2, ALL_RED=1)
REQ-028 v held 1 from reset release -> HG 12 clk, HY 8, AR_F 4, FG 16, FY 8, AR_H 4, then HG again; lamp codes per REQ-013.
REQ-029 v held 0 for 200 clk -> stays HG, highway=001, farm=100 throughout.
REQ-030 v=1 until FG entered, v=0 thereafter -> FY entered after 2 ticks (8 clk) of FG.
REQ-031 v pulsed high one clk between ticks in HG after min green -> ignored, stays HG.
REQ-032 rst pulled low mid-FG, asynchronously to clk -> highway=001, farm=100 before next clk edge; after release HG lasts >=12 clk.
REQ-033 PED_REQ_EN, v=0, ped_req one-clk pulse at clk 2 -> HY at 12 clk, ped_walk=1 for all 16 clk of FG, latch cleared.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp codes for the highway/farm-road intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    HG   = 3'd0,
    HY   = 3'd1,
    AR_F = 3'd2,
    FG   = 3'd3,
    FY   = 3'd4,
    AR_H = 3'd5
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Returns {highway, farm}; any code outside the six phases shows red both ways.
  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      HG:      lamps = {GREEN, RED};
      HY:      lamps = {YELLOW, RED};
      AR_F:    lamps = {RED, RED};
      FG:      lamps = {RED, GREEN};
      FY:      lamps = {RED, YELLOW};
      AR_H:    lamps = {RED, RED};
      default: lamps = {RED, RED};
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Prescaler: one-clk tick pulse every CLK_PER_TICK cycles, counter wraps to 0 on the tick.
module tick_gen #(
  parameter int CLK_PER_TICK = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Highway/farm-road phase controller with tick-based timing and farm-sensor gap-out.
// Optional pedestrian request (ped_req/ped_walk) is built when PED_REQ_EN is defined.
module traffic_phase_ctrl
  import traffic_pkg::state_t, traffic_pkg::HG, traffic_pkg::HY, traffic_pkg::AR_F,
         traffic_pkg::FG, traffic_pkg::FY, traffic_pkg::AR_H, traffic_pkg::lamps;
#(
  parameter int CLK_PER_TICK   = 50000000,
  parameter int HWY_MIN_GREEN  = 10,
  parameter int FARM_MAX_GREEN = 9,
  parameter int FARM_MIN_GREEN = 2,
  parameter int YELLOW         = 3,
  parameter int ALL_RED        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       v,
`ifdef PED_REQ_EN
  input  logic       ped_req,
  output logic       ped_walk,
`endif
  output logic [2:0] highway,
  output logic [2:0] farm,
  output logic [2:0] phase
);

  localparam int MAX_HF = (HWY_MIN_GREEN > FARM_MAX_GREEN) ? HWY_MIN_GREEN : FARM_MAX_GREEN;
  localparam int MAX_YA = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
  localparam int MAXD   = (MAX_HF > MAX_YA) ? MAX_HF : MAX_YA;
  localparam int TW     = $clog2(MAXD) + 1;

  localparam logic [TW-1:0] HMIN_L = TW'(HWY_MIN_GREEN - 1);
  localparam logic [TW-1:0] FMAX_L = TW'(FARM_MAX_GREEN - 1);
  localparam logic [TW-1:0] FMIN_L = TW'(FARM_MIN_GREEN - 1);
  localparam logic [TW-1:0] YEL_L  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] AR_L   = TW'(ALL_RED - 1);

  logic          tick;
  state_t        state, nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          demand, gap_ok;

  tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef PED_REQ_EN
  logic ped_pend, ped_serve;
  assign demand = v | ped_pend;
  // A farm green opened for a pedestrian runs to its maximum so the walk is not cut short.
  assign gap_ok = ~ped_serve;
`else
  assign demand = v;
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    nxt       = state;
    timer_nxt = timer;
    if (tick) begin
      timer_nxt = timer + TW'(1);
      case (state)
        HG: if (timer >= HMIN_L) begin
          timer_nxt = HMIN_L;
          if (demand) nxt = HY;
        end
        HY:   if (timer == YEL_L) nxt = AR_F;
        AR_F: if (timer == AR_L)  nxt = FG;
        FG:   if ((timer == FMAX_L) || (!v && gap_ok && (timer >= FMIN_L))) nxt = FY;
        FY:   if (timer == YEL_L) nxt = AR_H;
        AR_H: if (timer == AR_L)  nxt = HG;
        default: nxt = HG;
      endcase
    end
    // Illegal codes recover on the very next clk, tick or not.
    if (state > AR_H) nxt = HG;
    if (nxt != state) timer_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= HG;
      timer           <= '0;
      {highway, farm} <= lamps(HG);
      phase           <= HG;
    end else begin
      state           <= nxt;
      timer           <= timer_nxt;
      {highway, farm} <= lamps(nxt);
      phase           <= nxt;
    end
  end

`ifdef PED_REQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ped_pend  <= 1'b0;
      ped_serve <= 1'b0;
      ped_walk  <= 1'b0;
    end else begin
      if ((nxt == FG) && (state != FG)) ped_pend <= 1'b0;
      else if (ped_req)                 ped_pend <= 1'b1;
      if ((nxt == FG) && (state != FG)) ped_serve <= ped_pend;
      else if (nxt != FG)               ped_serve <= 1'b0;
      ped_walk <= (nxt == FG);
    end
  end
`endif

endmodule
